// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID/EXE hazard scoreboard.
// Forwarding select encoding and opcodes that skip src1.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef struct packed {
    logic       hazard;
    logic [1:0] sel;
  } fwd_t;

endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight write counter.
// One issue and up to two releases per cycle; releases past zero are dropped.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec0,
  input  logic             dec1,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic             underflow
);

  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

  logic [1:0]     ndec;
  logic [CNT_W:0] cur;
  logic [CNT_W:0] dec;
  logic [CNT_W:0] nxt;

  always_comb begin
    ndec      = {1'b0, dec0} + {1'b0, dec1};
    cur       = {1'b0, cnt};
    dec       = (CNT_W + 1)'(ndec);
    underflow = 1'b0;
    if (dec > cur) begin
      underflow = 1'b1;
      dec       = cur;
    end
    nxt = cur + {{CNT_W{1'b0}}, inc} - dec;
    if (nxt > MAX) nxt = MAX;
  end

  assign sat = (cur == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= nxt[CNT_W-1:0];
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EXE hazard scoreboard: in-flight write tracking, stall,
// per-source forwarding selects and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2,
  parameter int FWD_EN   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [3:0]          id_opcode,
  input  logic [REG_AW-1:0]   id_src1,
  input  logic [REG_AW-1:0]   id_src2,
  input  logic                id_two_src,
  input  logic                id_wb_en,
  input  logic [REG_AW-1:0]   id_dest,
  input  logic                exe_wb_en,
  input  logic [REG_AW-1:0]   exe_dest,
  input  logic                exe_is_load,
  input  logic                mem_wb_en,
  input  logic [REG_AW-1:0]   mem_dest,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_dest,
  input  logic                kill_valid,
  input  logic [REG_AW-1:0]   kill_dest,
  output logic                stall,
  output logic [1:0]          fwd_sel_a,
  output logic [1:0]          fwd_sel_b,
  output logic [NUM_REGS-1:0] busy,
  output logic                sb_err,
  output logic [31:0]         stall_cnt
);

  localparam int SLOTS = 2 ** REG_AW;

  logic [CNT_W-1:0] cnt [SLOTS];
  logic [SLOTS-1:0] sat;
  logic [SLOTS-1:0] uf;
  logic [SLOTS-1:0] nz;
  logic [SLOTS-1:0] one;
  logic             issue;
  logic             use1;
  logic             use2;
  fwd_t             pa;
  fwd_t             pb;

  // Slots beyond NUM_REGS read as idle so any address is safe to index.
  for (genvar r = 0; r < SLOTS; r++) begin : g_slot
    if (r < NUM_REGS) begin : g_cnt
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (issue & (id_dest == REG_AW'(r))),
        .dec0      (wb_valid & (wb_dest == REG_AW'(r))),
        .dec1      (kill_valid & (kill_dest == REG_AW'(r))),
        .cnt       (cnt[r]),
        .sat       (sat[r]),
        .underflow (uf[r])
      );
    end else begin : g_idle
      assign cnt[r] = '0;
      assign sat[r] = 1'b0;
      assign uf[r]  = 1'b0;
    end
    assign nz[r]  = (cnt[r] != '0);
    assign one[r] = (cnt[r] == CNT_W'(1));
  end

  function automatic fwd_t pick(input logic [REG_AW-1:0] s);
    logic pend;
    pend = nz[s] & ~(one[s] & wb_valid & (wb_dest == s));
    pick = '{hazard: 1'b0, sel: FWD_RF};
    if (FWD_EN == 0) begin
      pick.hazard = nz[s];
    end else if (exe_wb_en && exe_dest == s) begin
      if (exe_is_load) pick.hazard = 1'b1;
      else             pick.sel    = FWD_EXE;
    end else if (mem_wb_en && mem_dest == s) begin
      pick.sel = FWD_MEM;
    end else if (wb_valid && wb_dest == s) begin
      pick.sel = FWD_WB;
    end else if (pend) begin
      pick.hazard = 1'b1;
    end
  endfunction

  assign use1 = id_valid & ~(id_opcode == OP_MOV | id_opcode == OP_MVN);
  assign use2 = id_valid & id_two_src;
  assign pa   = pick(id_src1);
  assign pb   = pick(id_src2);

  assign stall = (use1 & pa.hazard)
               | (use2 & pb.hazard)
               | (id_valid & id_wb_en & sat[id_dest]);

  assign issue     = id_valid & id_wb_en & ~stall;
  assign fwd_sel_a = use1 ? pa.sel : FWD_RF;
  assign fwd_sel_b = use2 ? pb.sel : FWD_RF;
  assign busy      = nz[NUM_REGS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (|uf) sb_err <= 1'b1;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
